// File: rtl/contador_n_bits.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : contador_n_bits
// Description : WIDTH-bit synchronous multi-mode counter. Modes: up by one,
//               down by one, up by STEP, parallel load. All outputs are
//               registered. rco is a one-cycle carry/borrow pulse of the last
//               operation; ovf is a sticky wrap flag cleared by reset or load.
// Ports       : clk    - clock, all state updates on the rising edge
//               reset  - synchronous active-high reset, highest priority
//               enable - count enable for modes 00/01/10, ignored in mode 11
//               mode   - 00 up, 01 down, 10 up by STEP, 11 load
//               D      - parallel load value (mode 11 only)
//               load   - 1 in the cycle after a load was performed
//               rco    - carry/borrow of the last operation (pulse)
//               ovf    - sticky wrap flag
//               Q      - count value
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module contador_n_bits #(
    parameter int unsigned WIDTH = 32,      // legal range 2..64
    parameter logic [63:0] STEP  = 64'd3    // legal range 1..2^WIDTH-1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic             load,
    output logic             rco,
    output logic             ovf,
    output logic [WIDTH-1:0] Q
);

    localparam logic [1:0] c_MODE_UP   = 2'b00;
    localparam logic [1:0] c_MODE_DOWN = 2'b01;
    localparam logic [1:0] c_MODE_STEP = 2'b10;
    localparam logic [1:0] c_MODE_LOAD = 2'b11;

    // Step is taken modulo 2^WIDTH so a prescaler instance can reuse a wide
    // constant without a separate parameter.
    localparam logic [WIDTH-1:0] c_STEP = STEP[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             r_load;
    logic             r_rco;
    logic             r_ovf;

    // All three arithmetic results are carried at WIDTH+1 bits; the MSB is
    // the carry (up/step) or the borrow (down, since 0-1 sets bit WIDTH).
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH:0]   w_step;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_rco_nxt;
    logic             w_load_nxt;
    logic             w_ovf_nxt;

    assign w_inc  = {1'b0, r_q} + {{WIDTH{1'b0}}, 1'b1};
    assign w_dec  = {1'b0, r_q} - {{WIDTH{1'b0}}, 1'b1};
    assign w_step = {1'b0, r_q} + {1'b0, c_STEP};

    always_comb begin
        w_q_nxt    = r_q;
        w_rco_nxt  = 1'b0;
        w_load_nxt = 1'b0;
        w_ovf_nxt  = r_ovf;

        case (mode)
            c_MODE_UP: begin
                if (enable) begin
                    {w_rco_nxt, w_q_nxt} = w_inc;
                end
            end
            c_MODE_DOWN: begin
                if (enable) begin
                    {w_rco_nxt, w_q_nxt} = w_dec;
                end
            end
            c_MODE_STEP: begin
                // The step can jump over all-ones, so the wrap is taken from
                // the carry bit rather than from a terminal-count compare.
                if (enable) begin
                    {w_rco_nxt, w_q_nxt} = w_step;
                end
            end
            c_MODE_LOAD: begin
                w_q_nxt    = D;
                w_load_nxt = 1'b1;
            end
            default: begin
                w_q_nxt = r_q;
            end
        endcase

        // Sticky wrap: load clears it, any counting edge may only set it.
        if (mode == c_MODE_LOAD) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf | w_rco_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            r_load <= 1'b0;
            r_rco  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_load <= w_load_nxt;
            r_rco  <= w_rco_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign Q    = r_q;
    assign load = r_load;
    assign rco  = r_rco;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_contador_n_bits.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_contador_n_bits
// Description : Self-checking bench for contador_n_bits. An 8-bit/STEP=3
//               instance is driven from a vector table and an up-count loop
//               through an expected-value queue; a two-stage 4-bit cascade
//               and a 32-bit instance cover the width sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_n_bits;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       rst8 = 1'b1, en8 = 1'b0;
    logic [1:0] mode8 = 2'b00;
    logic [7:0] d8 = 8'h00;
    logic       load8, rco8, ovf8;
    logic [7:0] q8;

    contador_n_bits #(.WIDTH(8), .STEP(64'd3)) u_dut8 (
        .clk(clk), .reset(rst8), .enable(en8), .mode(mode8), .D(d8),
        .load(load8), .rco(rco8), .ovf(ovf8), .Q(q8)
    );

    // Two 4-bit stages, lower rco drives upper enable
    logic       rst4 = 1'b1, en4 = 1'b0;
    logic [1:0] mode4 = 2'b00;
    logic [3:0] d4 = 4'h0;
    logic       load_lo, rco_lo, ovf_lo, load_hi, rco_hi, ovf_hi;
    logic [3:0] q_lo, q_hi;

    contador_n_bits #(.WIDTH(4), .STEP(64'd3)) u_dut_lo (
        .clk(clk), .reset(rst4), .enable(en4), .mode(mode4), .D(d4),
        .load(load_lo), .rco(rco_lo), .ovf(ovf_lo), .Q(q_lo)
    );
    contador_n_bits #(.WIDTH(4), .STEP(64'd3)) u_dut_hi (
        .clk(clk), .reset(rst4), .enable(rco_lo), .mode(mode4), .D(d4),
        .load(load_hi), .rco(rco_hi), .ovf(ovf_hi), .Q(q_hi)
    );

    // 32-bit instance
    logic        rst32 = 1'b1, en32 = 1'b0;
    logic [1:0]  mode32 = 2'b00;
    logic [31:0] d32 = 32'h0;
    logic        load32, rco32, ovf32;
    logic [31:0] q32;

    contador_n_bits #(.WIDTH(32), .STEP(64'd3)) u_dut32 (
        .clk(clk), .reset(rst32), .enable(en32), .mode(mode32), .D(d32),
        .load(load32), .rco(rco32), .ovf(ovf32), .Q(q32)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic [7:0] q;
        logic       rco;
        logic       ld;
        logic       ovf;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       rco;
        logic       ld;
        logic       ovf;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare8();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty queue at t=%0t", $time);
        end else begin
            checks--;
            x = sb.pop_front();
            chk({x.tag, " Q"},    {56'd0, q8},    {56'd0, x.q});
            chk({x.tag, " rco"},  {63'd0, rco8},  {63'd0, x.rco});
            chk({x.tag, " load"}, {63'd0, load8}, {63'd0, x.ld});
            chk({x.tag, " ovf"},  {63'd0, ovf8},  {63'd0, x.ovf});
        end
    endtask

    // Drive one edge on the 8-bit instance; the expectation is queued with
    // the stimulus and checked 1 ns after the edge.
    task automatic step8(input logic r, input logic e, input logic [1:0] m,
                         input logic [7:0] d, input logic [7:0] eq,
                         input logic erco, input logic eld, input logic eovf,
                         input string tag);
        exp_t x;
        rst8 = r; en8 = e; mode8 = m; d8 = d;
        x.q = eq; x.rco = erco; x.ld = eld; x.ovf = eovf; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare8();
    endtask

    task automatic step32(input logic r, input logic e, input logic [1:0] m,
                          input logic [31:0] d, input logic [31:0] eq,
                          input logic erco, input logic eld, input logic eovf,
                          input string tag);
        rst32 = r; en32 = e; mode32 = m; d32 = d;
        @(posedge clk);
        #1;
        chk({tag, " Q32"},    {32'd0, q32},    {32'd0, eq});
        chk({tag, " rco32"},  {63'd0, rco32},  {63'd0, erco});
        chk({tag, " load32"}, {63'd0, load32}, {63'd0, eld});
        chk({tag, " ovf32"},  {63'd0, ovf32},  {63'd0, eovf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         exp_lo, exp_hi;
        logic       exp_lo_rco, exp_lo_ovf;
        logic [7:0] i8;

        // rst, en, mode, d, q, rco, ld, ovf
        vecs.push_back('{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset"});
        vecs.push_back('{1'b0, 1'b0, 2'd3, 8'h02, 8'h02, 1'b0, 1'b1, 1'b0, "load02"});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, "down1"});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "down0"});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, "down_wrap"});
        vecs.push_back('{1'b0, 1'b1, 2'd3, 8'hFD, 8'hFD, 1'b0, 1'b1, 1'b0, "loadFD"});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "step_wrap"});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1, "step03"});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h06, 1'b0, 1'b0, 1'b1, "step06"});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h09, 1'b0, 1'b0, 1'b1, "step09"});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b1, "step0C"});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b1, "step0F"});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, "up10"});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, "gate_up_a"});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, "gate_up_b"});
        vecs.push_back('{1'b0, 1'b0, 2'd1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, "gate_down"});
        vecs.push_back('{1'b0, 1'b0, 2'd2, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, "gate_step"});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, "gate_up_c"});
        vecs.push_back('{1'b0, 1'b0, 2'd3, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, "loadA5_en0"});
        vecs.push_back('{1'b0, 1'b0, 2'd3, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, "load_again"});
        vecs.push_back('{1'b1, 1'b1, 2'd3, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, "reset_vs_load"});
        vecs.push_back('{1'b0, 1'b0, 2'd3, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, "loadFF_a"});
        vecs.push_back('{1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_at_FF"});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, "after_reset"});
        vecs.push_back('{1'b0, 1'b0, 2'd3, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, "loadFF_b"});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "up_wrap"});
        vecs.push_back('{1'b0, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "gate_after_wrap"});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, "wrap_ovf_set"});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "wrap_again"});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, "rco_drops"});
        vecs.push_back('{1'b0, 1'b0, 2'd3, 8'hFE, 8'hFE, 1'b0, 1'b1, 1'b0, "loadFE"});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, "step_over_FF"});

        #1;

        // Reset then full up-count: wrap appears only on edge 256.
        step8(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "up_reset");
        for (int i = 1; i <= 256; i++) begin
            i8 = i[7:0];
            step8(1'b0, 1'b1, 2'd0, 8'h00, i8, (i == 256), 1'b0, (i == 256),
                  $sformatf("upcount%0d", i));
        end

        // Vector table
        for (int k = 0; k < vecs.size(); k++) begin
            step8(vecs[k].rst, vecs[k].en, vecs[k].mode, vecs[k].d,
                  vecs[k].q, vecs[k].rco, vecs[k].ld, vecs[k].ovf, vecs[k].name);
        end
        rst8 = 1'b1;

        // 4-bit cascade: upper stage advances one edge after the lower wrap.
        rst4 = 1'b1; en4 = 1'b1; mode4 = 2'd0;
        @(posedge clk);
        #1;
        chk("casc reset", {56'd0, q_hi, q_lo}, 64'd0);
        chk("casc reset rco", {62'd0, rco_hi, rco_lo}, 64'd0);
        rst4 = 1'b0;
        exp_lo = 0; exp_hi = 0; exp_lo_rco = 1'b0; exp_lo_ovf = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (exp_lo_rco) exp_hi = (exp_hi + 1) % 16;
            exp_lo_rco = (exp_lo == 15);
            exp_lo_ovf = exp_lo_ovf | exp_lo_rco;
            exp_lo = (exp_lo + 1) % 16;
            chk($sformatf("casc%0d Q", n), {56'd0, q_hi, q_lo},
                {56'd0, exp_hi[3:0], exp_lo[3:0]});
            chk($sformatf("casc%0d rco_lo", n), {63'd0, rco_lo}, {63'd0, exp_lo_rco});
            if (n == 16) chk("casc lag 16", {56'd0, q_hi, q_lo}, 64'h00);
            if (n == 17) chk("casc lag 17", {56'd0, q_hi, q_lo}, 64'h11);
            if (n == 255) chk("casc 0xFF", {56'd0, q_hi, q_lo}, 64'hFF);
        end
        chk("casc ovf_lo", {63'd0, ovf_lo}, 64'd1);
        rst4 = 1'b1;

        // 32-bit wrap from a preload near all-ones
        step32(1'b1, 1'b0, 2'd0, 32'h0,          32'h0,          1'b0, 1'b0, 1'b0, "w32 reset");
        step32(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, "w32 load");
        step32(1'b0, 1'b1, 2'd0, 32'h0,          32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "w32 up1");
        step32(1'b0, 1'b1, 2'd0, 32'h0,          32'h0000_0000, 1'b1, 1'b0, 1'b1, "w32 wrap");
        step32(1'b0, 1'b1, 2'd0, 32'h0,          32'h0000_0001, 1'b0, 1'b0, 1'b1, "w32 after");
        step32(1'b0, 1'b1, 2'd2, 32'h0,          32'h0000_0004, 1'b0, 1'b0, 1'b1, "w32 step");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
